// File: rtl/idu_stage_pkg.sv
// idu_stage_pkg: definitions shared by the decode stage and the execute unit.
//   - alu_op_e      : ALU operation codes (ADD 0 .. PASS_B 10)
//   - SEL_* consts  : left/right operand selects
//   - OPC_* consts  : RV32I major opcodes
//   - idu_bundle_t  : decoded control bundle (32-bit immediate, sign-extended
//                     to the datapath width by the stage)
//   - alu_from_funct: funct3/alt-bit to ALU op mapping for OP and OP-IMM
package idu_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic       SEL_LEFT_RS1  = 1'b0;
    localparam logic       SEL_LEFT_PC   = 1'b1;
    localparam logic [1:0] SEL_RIGHT_RS2 = 2'b00;
    localparam logic [1:0] SEL_RIGHT_IMM = 2'b01;
    localparam logic [1:0] SEL_RIGHT_4   = 2'b10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        sel_left;
        logic [1:0]  sel_right;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [2:0]  funct3;
        logic        illegal;
    } idu_bundle_t;

    // alt selects SUB (funct3 000) or SRA (funct3 101); the caller decides
    // whether funct7[5] may act as alt for the given opcode.
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_decode.sv
// idu_decode: purely combinational RV32I instruction -> control bundle.
// Ports:
//   inst   in  32  instruction word
//   bundle out     decoded idu_bundle_t (rd_wen already masked for rd = 0)
module idu_decode
    import idu_stage_pkg::*;
(
    input  logic [31:0] inst,
    output idu_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wen;

    assign opcode = inst[6:0];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        bundle        = '0;
        bundle.rs1    = inst[19:15];
        bundle.rs2    = inst[24:20];
        bundle.rd     = inst[11:7];
        bundle.funct3 = inst[14:12];
        wen           = 1'b0;
        case (opcode)
            OPC_LUI: begin
                bundle.alu_op    = ALU_PASS_B;
                bundle.sel_right = SEL_RIGHT_IMM;
                bundle.imm       = imm_u;
                wen              = 1'b1;
            end
            OPC_AUIPC: begin
                bundle.sel_left  = SEL_LEFT_PC;
                bundle.sel_right = SEL_RIGHT_IMM;
                bundle.imm       = imm_u;
                wen              = 1'b1;
            end
            OPC_JAL: begin
                bundle.sel_left  = SEL_LEFT_PC;
                bundle.sel_right = SEL_RIGHT_4;
                bundle.imm       = imm_j;
                wen              = 1'b1;
            end
            OPC_JALR: begin
                bundle.sel_left  = SEL_LEFT_PC;
                bundle.sel_right = SEL_RIGHT_4;
                bundle.imm       = imm_i;
                wen              = 1'b1;
            end
            OPC_OP_IMM: begin
                // inst[30] is immediate data for ADDI, so it only means SRA
                bundle.alu_op    = alu_from_funct(inst[14:12],
                                                  (inst[14:12] == 3'b101) && inst[30]);
                bundle.sel_right = SEL_RIGHT_IMM;
                bundle.imm       = imm_i;
                wen              = 1'b1;
            end
            OPC_OP: begin
                bundle.alu_op = alu_from_funct(inst[14:12], inst[30]);
                wen           = 1'b1;
            end
            OPC_BRANCH: begin
                case (inst[14:13])
                    2'b10:   bundle.alu_op = ALU_SLT;
                    2'b11:   bundle.alu_op = ALU_SLTU;
                    default: bundle.alu_op = ALU_SUB;
                endcase
                bundle.imm = imm_b;
            end
            OPC_LOAD: begin
                bundle.sel_right = SEL_RIGHT_IMM;
                bundle.imm       = imm_i;
                wen              = 1'b1;
            end
            OPC_STORE: begin
                bundle.sel_right = SEL_RIGHT_IMM;
                bundle.imm       = imm_s;
            end
            OPC_SYSTEM: begin
                bundle.imm = imm_i;
            end
            default: begin
                bundle.illegal = 1'b1;
            end
        endcase
        bundle.rd_wen = wen && (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/idu_stage.sv
// idu_stage: registered instruction-decode stage between fetch and execute.
// Handshakes: a beat moves on a port when valid && ready are both high at a
// rising edge; the sender holds its data stable while valid && !ready.
// Ports:
//   clk, rst (async, active-high), flush (drop held + incoming this cycle)
//   in_valid/in_ready, in_inst[31:0], in_pc[WIDTH-1:0]   from fetch
//   out_valid/out_ready, out_pc, alu_op, alu_sel_left, alu_sel_right, imm,
//   rs1_addr, rs2_addr, rd_addr, rd_wen, funct3, illegal  to execute
// Build option: IDU_SKID_EN adds a one-entry skid register so that in_ready
// is a flop output instead of a combinational function of out_ready.
module idu_stage
    import idu_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [3:0]       alu_op,
    output logic             alu_sel_left,
    output logic [1:0]       alu_sel_right,
    output logic [WIDTH-1:0] imm,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic             rd_wen,
    output logic [2:0]       funct3,
    output logic             illegal
);

    idu_bundle_t      dec_b;
    idu_bundle_t      out_b;
    logic [WIDTH-1:0] out_pc_q;
    logic             out_valid_q;
    logic             accept;

    idu_decode u_decode (
        .inst   (in_inst),
        .bundle (dec_b)
    );

    assign accept = in_valid && in_ready;

`ifdef IDU_SKID_EN
    idu_bundle_t      skid_b;
    logic [WIDTH-1:0] skid_pc;
    logic             skid_valid;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_b       <= '0;
            out_pc_q    <= '0;
            skid_valid  <= 1'b0;
            skid_b      <= '0;
            skid_pc     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so the only move is skid -> output
            if (out_ready) begin
                out_b      <= skid_b;
                out_pc_q   <= skid_pc;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q && !out_ready) begin
                skid_b     <= dec_b;
                skid_pc    <= in_pc;
                skid_valid <= 1'b1;
            end else begin
                out_b       <= dec_b;
                out_pc_q    <= in_pc;
                out_valid_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_b       <= '0;
            out_pc_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_b       <= dec_b;
            out_pc_q    <= in_pc;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign alu_op        = out_b.alu_op;
    assign alu_sel_left  = out_b.sel_left;
    assign alu_sel_right = out_b.sel_right;
    assign imm           = WIDTH'($signed(out_b.imm));
    assign rs1_addr      = out_b.rs1;
    assign rs2_addr      = out_b.rs2;
    assign rd_addr       = out_b.rd;
    assign rd_wen        = out_b.rd_wen;
    assign funct3        = out_b.funct3;
    assign illegal       = out_b.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: directed vectors with hand-computed expected bundles.
// Accepted instructions push their expected bundle; a monitor pops and
// compares on every output transfer.
module tb_idu_stage;

    localparam int W  = 32;
    localparam int VW = 91;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_inst = '0;
    logic [W-1:0]  in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_pc;
    logic [3:0]    alu_op;
    logic          alu_sel_left;
    logic [1:0]    alu_sel_right;
    logic [W-1:0]  imm;
    logic [4:0]    rs1_addr, rs2_addr, rd_addr;
    logic          rd_wen;
    logic [2:0]    funct3;
    logic          illegal;

    int checks   = 0;
    int failures = 0;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] got_vec;

    idu_stage #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .alu_op        (alu_op),
        .alu_sel_left  (alu_sel_left),
        .alu_sel_right (alu_sel_right),
        .imm           (imm),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .rd_wen        (rd_wen),
        .funct3        (funct3),
        .illegal       (illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    assign got_vec = {out_pc, alu_op, alu_sel_left, alu_sel_right, imm,
                      rs1_addr, rs2_addr, rd_addr, rd_wen, funct3, illegal};

    function automatic logic [VW-1:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                         input logic sl, input logic [1:0] sr,
                                         input logic [31:0] im, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] rd,
                                         input logic wen, input logic [2:0] f3,
                                         input logic ill);
        return {pc, op, sl, sr, im, r1, r2, rd, wen, f3, ill};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // scoreboard monitor: one pop per output transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h exp=none", got_vec);
            end else begin
                logic [VW-1:0] e;
                e = exp_q.pop_front();
                if (got_vec !== e) begin
                    failures++;
                    $display("FAIL bundle got=%h exp=%h", got_vec, e);
                end
            end
        end
    end

    // driver: present one instruction until accepted (bounded wait)
    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [VW-1:0] exp, input logic fl);
        int waited;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        flush    = fl;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (!fl) exp_q.push_back(exp);
                break;
            end
            waited++;
            if (waited > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout got=in_ready_low exp=accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VW-1:0] snap;
        int waited;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {90'd0, out_valid}, '0);
        check("reset_in_ready", {90'd0, in_ready}, {90'd0, 1'b1});
        check("reset_bundle", got_vec, '0);
        rst = 1'b0;
        idle(1);

        // single instructions, out_ready high
        send(32'h00510093, 32'h0000_0100, mk(32'h100, 4'd0, 1'b0, 2'b01, 32'd5, 5'd2, 5'd5, 5'd1, 1'b1, 3'd0, 1'b0), 1'b0);
        send(32'h123452B7, 32'h0000_0104, mk(32'h104, 4'd10, 1'b0, 2'b01, 32'h12345000, 5'd8, 5'd3, 5'd5, 1'b1, 3'd5, 1'b0), 1'b0);
        send(32'hFFDFF0EF, 32'h8000_0010, mk(32'h80000010, 4'd0, 1'b1, 2'b10, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd1, 1'b1, 3'd7, 1'b0), 1'b0);
        send(32'h0020A423, 32'h0000_0200, mk(32'h200, 4'd0, 1'b0, 2'b01, 32'd8, 5'd1, 5'd2, 5'd8, 1'b0, 3'd2, 1'b0), 1'b0);
        send(32'h0041D863, 32'h0000_0204, mk(32'h204, 4'd3, 1'b0, 2'b00, 32'd16, 5'd3, 5'd4, 5'd16, 1'b0, 3'd5, 1'b0), 1'b0);
        // illegal opcode and rd = 0 writeback suppression
        send(32'h0000007F, 32'h0000_0300, mk(32'h300, 4'd0, 1'b0, 2'b00, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1), 1'b0);
        send(32'h00108013, 32'h0000_0304, mk(32'h304, 4'd0, 1'b0, 2'b01, 32'd1, 5'd1, 5'd1, 5'd0, 1'b0, 3'd0, 1'b0), 1'b0);
        idle(3);

        // three back-to-back with a 3-cycle output stall
        out_ready = 1'b0;
        fork
            begin
                send(32'h002081B3, 32'h0000_0400, mk(32'h400, 4'd0, 1'b0, 2'b00, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 1'b0), 1'b0);
                send(32'h40628233, 32'h0000_0404, mk(32'h404, 4'd1, 1'b0, 2'b00, 32'd0, 5'd5, 5'd6, 5'd4, 1'b1, 3'd0, 1'b0), 1'b0);
                send(32'h409453B3, 32'h0000_0408, mk(32'h408, 4'd7, 1'b0, 2'b00, 32'd0, 5'd8, 5'd9, 5'd7, 1'b1, 3'd5, 1'b0), 1'b0);
            end
            begin
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 20) begin
                    @(negedge clk);
                    waited++;
                end
                snap = got_vec;
                check("stall_valid", {90'd0, out_valid}, {90'd0, 1'b1});
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {got_vec[VW-1:1], out_valid}, {snap[VW-1:1], 1'b1});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // flush with a simultaneous accept while out_valid is high
        out_ready = 1'b0;
        send(32'h00510093, 32'h0000_0500, mk(32'h500, 4'd0, 1'b0, 2'b01, 32'd5, 5'd2, 5'd5, 5'd1, 1'b1, 3'd0, 1'b0), 1'b0);
        out_ready = 1'b1;
        send(32'h123452B7, 32'h0000_0504, '0, 1'b1);
        check("flush_out_valid", {90'd0, out_valid}, '0);
        idle(3);

        // flush while an entry is held in a stall
        out_ready = 1'b0;
        send(32'h00108013, 32'h0000_0600, '0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        check("flush_held", {90'd0, out_valid}, '0);
        out_ready = 1'b1;
        idle(3);

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(32'hFFDFF0EF, 32'h8000_0700, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("rst_async_valid", {90'd0, out_valid}, '0);
        check("rst_async_bundle", got_vec, '0);
        check("rst_async_in_ready", {90'd0, in_ready}, {90'd0, 1'b1});
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("post_rst_in_ready", {90'd0, in_ready}, {90'd0, 1'b1});

        // traffic after reset still flows
        send(32'h40628233, 32'h0000_0800, mk(32'h800, 4'd1, 1'b0, 2'b00, 32'd0, 5'd5, 5'd6, 5'd4, 1'b1, 3'd0, 1'b0), 1'b0);
        idle(4);
        check("queue_drained", VW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
